gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl: RTL



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_pkg.sv | 23 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_addf.sv | 24 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_pkg
// Shared definitions for the bit-serial adder sequencer:
//   - state_t      : FSM state codes (2-bit binary, code 3 is illegal)
//   - WIDTH_MIN/MAX: legal operand width range
//   - width_ok()   : legality check used at elaboration time
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_addf.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf
// Behavioural model of the library full-adder cell used by the serial adder.
// Ports:
//   A, B, CI : addend bits and carry-in
//   S, CO    : sum and carry-out (purely combinational)
//   VDD, VSS : supply pins, present only when USE_POWER_PINS is defined
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__addf (
`ifdef USE_POWER_PINS
   inout  wire  VDD,
   inout  wire  VSS,
`endif
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic CO,
   output logic S
);

   assign S  = A ^ B ^ CI;
   assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl
// Bit-serial adder sequencer: {CO,S} = A + B + CI computed LSB-first through a
// single full-adder cell over WIDTH cycles, carry registered between cycles.
// Ports:
//   CLK        : clock, rising edge
//   RN         : asynchronous active-low reset
//   START      : request, accepted in IDLE or DONE only
//   A, B, CI   : operands / carry-in, sampled on the accepting edge only
//   BUSY       : high while the adder is stepping (RUN)
//   DONE       : one-cycle pulse, S/CO hold the new result
//   S, CO      : registered result, holds the last completed operation
//   VDD, VSS   : supply pass-through to the cell (USE_POWER_PINS only)
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl
   import gf180mcu_fd_sc_mcu7t5v0__addf_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
   inout  wire              VDD,
   inout  wire              VSS,
`endif
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             CO
);

   if (!width_ok(WIDTH)) begin : g_width_err
      $error("addf_serial_ctrl: WIDTH=%0d outside legal range 2..32", WIDTH);
   end

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_co;

   logic             w_sum;
   logic             w_co;

   gf180mcu_fd_sc_mcu7t5v0__addf u_addf (
`ifdef USE_POWER_PINS
      .VDD (VDD),
      .VSS (VSS),
`endif
      .A   (r_a_sh[0]),
      .B   (r_b_sh[0]),
      .CI  (r_carry),
      .CO  (w_co),
      .S   (w_sum)
   );

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state  <= ST_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_s      <= '0;
         r_co     <= 1'b0;
      end else begin
         case (r_state)
            // DONE behaves like IDLE for acceptance, which gives back-to-back
            // operation with no idle cycle when START is held.
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (START) begin
                  r_a_sh  <= A;
                  r_b_sh  <= B;
                  r_carry <= CI;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_sum_sh <= {w_sum, r_sum_sh[WIDTH-1:1]};
               r_carry  <= w_co;
               if (r_cnt == LAST_CNT) begin
                  // Result registers update only here, so S/CO hold the
                  // previous result for the whole RUN phase.
                  r_s     <= {w_sum, r_sum_sh[WIDTH-1:1]};
                  r_co    <= w_co;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               // Illegal code 3: recover to IDLE on the next edge.
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY = r_busy;
   assign DONE = r_done;
   assign S    = r_s;
   assign CO   = r_co;

endmodule
